// File: rtl/ctrl_pipe.sv
// Registered main control for the yIF/yID/yEX/yDM/yWB pipeline: decodes ID and carries controls through EX/MEM/WB.
// Latency: ins sampled at edge k -> ex_* after k, mem_* after k+1, wb_* after k+2; retired counts WB exits.
// Backpressure: stall/flush/invalid/illegal load a bubble into EX; MEM and WB always advance.
// Optional feature macro: CTRL_PIPE_ILLEGAL_TRAP_EN (sticky illegal-opcode flag; otherwise illegal is tied to 0).
module ctrl_pipe #(
    parameter int ALUOPW = 3,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ins,
    input  logic              ins_valid,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_RegDst,
    output logic              ex_ALUSrc,
    output logic [ALUOPW-1:0] ex_op,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              mem_valid,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic              wb_Mem2Reg,
    output logic [CNTW-1:0]   retired,
    output logic              illegal
);

    // EX slot carries every control; MEM and WB keep only what they still need.
    typedef struct packed {
        logic              valid;
        logic              reg_dst;
        logic              alu_src;
        logic [ALUOPW-1:0] op;
        logic              branch;
        logic              jump;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem2reg;
    } ex_ctrl_t;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem2reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem2reg;
    } wb_ctrl_t;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_ins;
    ex_ctrl_t   w_dec;
    logic       w_legal;
    logic       w_accept;
    logic       w_load;

    ex_ctrl_t        r_ex;
    mem_ctrl_t       r_mem;
    wb_ctrl_t        r_wb;
    logic [CNTW-1:0] r_retired;

    assign w_opcode     = ins[31:26];
    assign w_funct      = ins[5:0];
    // Register fields are the datapath's business, not control's.
    assign w_unused_ins = ^ins[25:6];

    // Opcode/funct decode; anything unrecognised collapses to an all-zero bubble.
    always_comb begin
        w_dec   = '0;
        w_legal = 1'b0;
        case (w_opcode)
            6'h00: begin
                w_legal         = 1'b1;
                w_dec.reg_dst   = 1'b1;
                w_dec.reg_write = 1'b1;
                case (w_funct)
                    6'h20:   w_dec.op = ALUOPW'(3'b010);
                    6'h22:   w_dec.op = ALUOPW'(3'b110);
                    6'h24:   w_dec.op = ALUOPW'(3'b000);
                    6'h25:   w_dec.op = ALUOPW'(3'b001);
                    6'h2a:   w_dec.op = ALUOPW'(3'b111);
                    default: w_legal  = 1'b0;
                endcase
            end
            6'h23: begin
                w_legal         = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.mem2reg   = 1'b1;
                w_dec.op        = ALUOPW'(3'b010);
            end
            6'h2b: begin
                w_legal         = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.op        = ALUOPW'(3'b010);
            end
            6'h04: begin
                w_legal         = 1'b1;
                w_dec.branch    = 1'b1;
                w_dec.op        = ALUOPW'(3'b110);
            end
            6'h02: begin
                w_legal         = 1'b1;
                w_dec.jump      = 1'b1;
                w_dec.op        = ALUOPW'(3'b010);
            end
            6'h08: begin
                w_legal         = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.op        = ALUOPW'(3'b010);
            end
            default: w_legal = 1'b0;
        endcase
        if (w_legal) begin
            w_dec.valid = 1'b1;
        end else begin
            w_dec = '0;
        end
    end

    // stall and flush are symmetric: either one alone kills the ID->EX load.
    assign w_accept = ins_valid & ~stall & ~flush;
    assign w_load   = w_accept & w_legal;

    // Pipeline registers and retire counter; reset drops every in-flight slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            r_retired <= '0;
        end else begin
            r_ex      <= w_load ? w_dec : '0;
            r_mem     <= '{valid: r_ex.valid, mem_read: r_ex.mem_read, mem_write: r_ex.mem_write,
                           reg_write: r_ex.reg_write, mem2reg: r_ex.mem2reg};
            r_wb      <= '{valid: r_mem.valid, reg_write: r_mem.reg_write, mem2reg: r_mem.mem2reg};
            if (r_wb.valid) begin
                r_retired <= r_retired + CNTW'(1);
            end
        end
    end

`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky trap: set when an accepted slot turns out to be an illegal encoding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign ex_valid     = r_ex.valid;
    assign ex_RegDst    = r_ex.reg_dst;
    assign ex_ALUSrc    = r_ex.alu_src;
    assign ex_op        = r_ex.op;
    assign ex_branch    = r_ex.branch;
    assign ex_jump      = r_ex.jump;
    assign mem_valid    = r_mem.valid;
    assign mem_MemRead  = r_mem.mem_read;
    assign mem_MemWrite = r_mem.mem_write;
    assign wb_valid     = r_wb.valid;
    assign wb_RegWrite  = r_wb.reg_write;
    assign wb_Mem2Reg   = r_wb.mem2reg;
    assign retired      = r_retired;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios then randomized traffic against a history-based model.
// Latency: checks 1 time unit after each rising edge.
// Backpressure: stall/flush driven directly; a second instance with a 4-bit counter exercises wrap.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ins;
    logic        ins_valid;
    logic        stall;
    logic        flush;

    logic        ex_valid, ex_RegDst, ex_ALUSrc, ex_branch, ex_jump;
    logic [2:0]  ex_op;
    logic        mem_valid, mem_MemRead, mem_MemWrite;
    logic        wb_valid, wb_RegWrite, wb_Mem2Reg;
    logic [15:0] retired;
    logic        illegal;

    logic        ex_valid4, ex_RegDst4, ex_ALUSrc4, ex_branch4, ex_jump4;
    logic [2:0]  ex_op4;
    logic        mem_valid4, mem_MemRead4, mem_MemWrite4;
    logic        wb_valid4, wb_RegWrite4, wb_Mem2Reg4;
    logic [3:0]  retired4;
    logic        illegal4;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.ALUOPW(3), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .ins_valid(ins_valid), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_op(ex_op),
        .ex_branch(ex_branch), .ex_jump(ex_jump),
        .mem_valid(mem_valid), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_Mem2Reg(wb_Mem2Reg),
        .retired(retired), .illegal(illegal)
    );

    ctrl_pipe #(.ALUOPW(3), .CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ins(ins), .ins_valid(ins_valid), .stall(stall), .flush(flush),
        .ex_valid(ex_valid4), .ex_RegDst(ex_RegDst4), .ex_ALUSrc(ex_ALUSrc4), .ex_op(ex_op4),
        .ex_branch(ex_branch4), .ex_jump(ex_jump4),
        .mem_valid(mem_valid4), .mem_MemRead(mem_MemRead4), .mem_MemWrite(mem_MemWrite4),
        .wb_valid(wb_valid4), .wb_RegWrite(wb_RegWrite4), .wb_Mem2Reg(wb_Mem2Reg4),
        .retired(retired4), .illegal(illegal4)
    );

    // Control word layout: valid RegDst ALUSrc op[2:0] branch jump MemRead MemWrite RegWrite Mem2Reg
    localparam logic [11:0] C_ADD  = 12'b1_1_0_010_0_0_0_0_1_0;
    localparam logic [11:0] C_SUB  = 12'b1_1_0_110_0_0_0_0_1_0;
    localparam logic [11:0] C_AND  = 12'b1_1_0_000_0_0_0_0_1_0;
    localparam logic [11:0] C_OR   = 12'b1_1_0_001_0_0_0_0_1_0;
    localparam logic [11:0] C_SLT  = 12'b1_1_0_111_0_0_0_0_1_0;
    localparam logic [11:0] C_LW   = 12'b1_0_1_010_0_0_1_0_1_1;
    localparam logic [11:0] C_SW   = 12'b1_0_1_010_0_0_0_1_0_0;
    localparam logic [11:0] C_BEQ  = 12'b1_0_0_110_1_0_0_0_0_0;
    localparam logic [11:0] C_J    = 12'b1_0_0_010_0_1_0_0_0_0;
    localparam logic [11:0] C_ADDI = 12'b1_0_1_010_0_0_0_0_1_0;

    // Reference decode straight from the instruction table.
    function automatic logic [11:0] ref_decode(input logic [31:0] i);
        logic [5:0] opc;
        logic [5:0] fn;
        opc = i[31:26];
        fn  = i[5:0];
        if (opc == 6'h00) begin
            if (fn == 6'h20) return C_ADD;
            if (fn == 6'h22) return C_SUB;
            if (fn == 6'h24) return C_AND;
            if (fn == 6'h25) return C_OR;
            if (fn == 6'h2a) return C_SLT;
            return 12'h000;
        end
        if (opc == 6'h23) return C_LW;
        if (opc == 6'h2b) return C_SW;
        if (opc == 6'h04) return C_BEQ;
        if (opc == 6'h02) return C_J;
        if (opc == 6'h08) return C_ADDI;
        return 12'h000;
    endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] fn);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'h00, mid, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] opc);
        logic [25:0] rest;
        rest = 26'($urandom);
        return {opc, rest};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: history of what was inserted into EX each edge (newest last), retire count, trap flag.
    logic [11:0] hist[$];
    int          m_ret = 0;
    logic        m_ill = 1'b0;

    task automatic check_all();
        logic [11:0] e;
        logic [11:0] m;
        logic [11:0] w;
        e = hist[hist.size()-1];
        m = hist[hist.size()-2];
        w = hist[hist.size()-3];
        chk("ex", {24'h0, ex_valid, ex_RegDst, ex_ALUSrc, ex_op, ex_branch, ex_jump}, {24'h0, e[11:4]});
        chk("mem", {29'h0, mem_valid, mem_MemRead, mem_MemWrite}, {29'h0, m[11], m[3], m[2]});
        chk("wb", {29'h0, wb_valid, wb_RegWrite, wb_Mem2Reg}, {29'h0, w[11], w[1], w[0]});
        chk("retired", {16'h0, retired}, 32'(m_ret % 65536));
        chk("retired4", {28'h0, retired4}, 32'(m_ret % 16));
        chk("illegal", {31'h0, illegal}, {31'h0, m_ill});
    endtask

    task automatic tick(input logic [31:0] i, input logic v, input logic st, input logic fl, input logic rn);
        logic [11:0] d;
        logic        acc;
        @(negedge clk);
        ins = i; ins_valid = v; stall = st; flush = fl; rst_n = rn;
        @(posedge clk);
        if (!rn) begin
            hist.delete();
            repeat (3) hist.push_back(12'h000);
            m_ret = 0;
            m_ill = 1'b0;
        end else begin
            if (hist[hist.size()-3][11]) m_ret++;
            d   = ref_decode(i);
            acc = v && !st && !fl;
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
            if (acc && d == 12'h000) m_ill = 1'b1;
`endif
            hist.push_back(acc ? d : 12'h000);
            if (hist.size() > 6) void'(hist.pop_front());
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_ins();
        int k;
        k = $urandom_range(0, 11);
        case (k)
            0:  return mk_r(6'h20);
            1:  return mk_r(6'h22);
            2:  return mk_r(6'h24);
            3:  return mk_r(6'h25);
            4:  return mk_r(6'h2a);
            5:  return mk_i(6'h23);
            6:  return mk_i(6'h2b);
            7:  return mk_i(6'h04);
            8:  return mk_i(6'h02);
            9:  return mk_i(6'h08);
            10: return mk_i(6'($urandom));
            default: return mk_r(6'($urandom));
        endcase
    endfunction

    initial begin
        repeat (3) hist.push_back(12'h000);
        ins = '0; ins_valid = 1'b0; stall = 1'b0; flush = 1'b0; rst_n = 1'b0;

        // Reset held for two edges with a valid add presented.
        tick(mk_r(6'h20), 1'b1, 1'b0, 1'b0, 1'b0);
        tick(mk_r(6'h20), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_retired", {16'h0, retired}, 32'd0);
        tick(mk_r(6'h20), 1'b1, 1'b0, 1'b0, 1'b1);
        chk("first_add_op", {29'h0, ex_op}, 32'b010);
        chk("first_add_regdst", {31'h0, ex_RegDst}, 32'd1);

        // Back-to-back stream from a clean reset.
        tick(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(mk_r(6'h20), 1'b1, 1'b0, 1'b0, 1'b1);
        tick(mk_i(6'h23), 1'b1, 1'b0, 1'b0, 1'b1);
        tick(mk_i(6'h2b), 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lw_mem_read", {31'h0, mem_MemRead}, 32'd1);
        tick(mk_i(6'h04), 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lw_wb_mem2reg", {31'h0, wb_Mem2Reg}, 32'd1);
        tick(mk_i(6'h02), 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sw_wb_regwrite", {30'h0, wb_valid, wb_RegWrite}, 32'b10);
        tick(mk_i(6'h08), 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) tick(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("retired_six", {16'h0, retired}, 32'd6);

        // Stalled lw becomes a bubble, then is re-presented.
        tick(mk_i(6'h23), 1'b1, 1'b1, 1'b0, 1'b1);
        chk("stall_bubble", {26'h0, ex_valid, ex_RegDst, ex_ALUSrc, ex_op, ex_branch, ex_jump}, 32'd0);
        tick(mk_i(6'h23), 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) tick(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stall_retire_once", {16'h0, retired}, 32'd7);

        // stall and flush together on a store.
        tick(mk_i(6'h2b), 1'b1, 1'b1, 1'b1, 1'b1);
        tick(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sf_no_store", {31'h0, mem_MemWrite}, 32'd0);
        tick(mk_i(6'h2b), 1'b1, 1'b0, 1'b1, 1'b1);
        tick(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_no_store", {31'h0, mem_MemWrite}, 32'd0);

        // Illegal encodings.
        tick(mk_i(6'h3f), 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
        chk("trap_set", {31'h0, illegal}, 32'd1);
`else
        chk("trap_off", {31'h0, illegal}, 32'd0);
`endif
        tick(mk_r(6'h00), 1'b1, 1'b0, 1'b0, 1'b1);
        chk("illegal_r_bubble", {31'h0, ex_valid}, 32'd0);
        repeat (3) tick(mk_r(6'h20), 1'b1, 1'b0, 1'b0, 1'b1);
        tick(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("trap_cleared", {31'h0, illegal}, 32'd0);

        // Wrap of the narrow counter: 17 adds retire.
        repeat (17) tick(mk_r(6'h20), 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) tick(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap17", {28'h0, retired4}, 32'd1);

        // Randomized traffic with occasional mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            tick(rand_ins(),
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 299) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
